gray_counter_multi: RTL and testbench

Multi-channel, parametrised successor to the single-button Gray counter system. Each of NCH channels takes a raw push-button, synchronises and debounces it, and turns every accepted press into one up or down step of an N-bit counter shown on the LEDs as Gray code. Channels can wrap or saturate at the ends of the range and report when they reach one. The block sits between the board buttons and LEDs and replaces the single-channel system at top level.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/debounce_pulse.sv | 57 +++++
 rtl/gray_counter_multi.sv | 83 ++++++++
 tb/tb_gray_counter_multi.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for the multi-channel Gray counter.
//   clog2    : ceiling log2, sizes the debounce counter (DELAY+1 states)
//   bin2gray : binary to reflected Gray, callers cast to their own width
package gray_pkg;

  localparam int GRAY_MAX_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Operates on the widest supported counter. Upper bits are zero for
  // narrower counters, so truncating the result is exact.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/debounce_pulse.sv
// One push-button channel: 2-FF synchroniser, debouncer and press detect.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   btn  : raw asynchronous button
//   step : one-cycle pulse per accepted (debounced) press
module debounce_pulse
  import gray_pkg::*;
#(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step
);

  localparam int              CW  = (clog2(DELAY + 1) < 1) ? 1 : clog2(DELAY + 1);
  localparam logic [CW-1:0]   LIM = CW'(DELAY);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d, stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounced state flips only after DELAY consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s2_q != stable_q) begin
      if (cnt_q + CW'(1) == LIM) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_q         <= btn;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  // Rising edge of the debounced state only; releases give no step.
  assign step = stable_q & ~stable_dly_q;

endmodule

// File: rtl/gray_counter_multi.sv
// NCH independent button-driven up/down counters shown as Gray code.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   btn  : raw buttons, bit c -> channel c
//   dir  : per-channel direction, 1 = up, 0 = down (used in the step cycle)
//   clr  : synchronous per-channel clear, wins over a step
//   leds : Gray value, channel c at [c*N +: N]
//   wrap : registered one-cycle pulse when a step crosses/hits a range end
module gray_counter_multi
  import gray_pkg::*;
#(
  parameter int N        = 4,
  parameter int DELAY    = 4,
  parameter int NCH      = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   btn,
  input  logic [NCH-1:0]   dir,
  input  logic [NCH-1:0]   clr,
  output logic [NCH*N-1:0] leds,
  output logic [NCH-1:0]   wrap
);

  localparam logic [N-1:0] MAXV = {N{1'b1}};
  localparam bit           SAT  = (SATURATE != 0);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic         step;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;

    debounce_pulse #(.DELAY(DELAY)) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[c]),
      .step (step)
    );

    always_comb begin
      b_d    = b_q;
      wrap_d = 1'b0;
      if (clr[c]) begin
        b_d = '0;
      end else if (step) begin
        if (dir[c]) begin
          if (b_q == MAXV) begin
            wrap_d = 1'b1;
            b_d    = SAT ? MAXV : '0;
          end else begin
            b_d = b_q + N'(1);
          end
        end else begin
          if (b_q == '0) begin
            wrap_d = 1'b1;
            b_d    = SAT ? '0 : MAXV;
          end else begin
            b_d = b_q - N'(1);
          end
        end
      end
      gray_d = N'(bin2gray(GRAY_MAX_W'(b_d)));
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        b_q    <= '0;
        gray_q <= '0;
        wrap_q <= 1'b0;
      end else begin
        b_q    <= b_d;
        gray_q <= gray_d;
        wrap_q <= wrap_d;
      end
    end

    assign leds[c*N +: N] = gray_q;
    assign wrap[c]        = wrap_q;
  end

endmodule

// File: tb/tb_gray_counter_multi.sv
module tb_gray_counter_multi;
  localparam int N = 4, DELAY = 4, NCH = 2;

  logic       clk = 1'b0, rst = 1'b0;
  logic [1:0] btn_a = '0, dir_a = '0, clr_a = '0;
  logic [1:0] btn_b = '0, dir_b = '0, clr_b = '0;
  logic [7:0] leds_a, leds_b;
  logic [1:0] wrap_a, wrap_b;

  int checks = 0, errors = 0;
  int mdl [2][2];
  logic [7:0] pre_a, post_a, pre_b, post_b, epre_a, epre_b;
  logic [1:0] w_a, wn_a, w_b, wn_b, ew_a, ew_b;

  always #5 clk = ~clk;

  gray_counter_multi #(.N(N), .DELAY(DELAY), .NCH(NCH), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .btn(btn_a), .dir(dir_a), .clr(clr_a), .leds(leds_a), .wrap(wrap_a));
  gray_counter_multi #(.N(N), .DELAY(DELAY), .NCH(NCH), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .btn(btn_b), .dir(dir_b), .clr(clr_b), .leds(leds_b), .wrap(wrap_b));

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---- behavioural reference: plain integer counters per channel ----
  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [7:0] exp_leds(input int inst);
    return {gray(mdl[inst][1]), gray(mdl[inst][0])};
  endfunction

  function automatic logic [1:0] mstep(input int inst, input logic [1:0] m, d, c);
    logic [1:0] w;
    w = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (c[ch]) mdl[inst][ch] = 0;
      else if (m[ch]) begin
        if (d[ch]) begin
          if (mdl[inst][ch] == 15) begin w[ch] = 1'b1; if (inst == 0) mdl[inst][ch] = 0; end
          else mdl[inst][ch] = mdl[inst][ch] + 1;
        end else begin
          if (mdl[inst][ch] == 0) begin w[ch] = 1'b1; if (inst == 0) mdl[inst][ch] = 15; end
          else mdl[inst][ch] = mdl[inst][ch] - 1;
        end
      end
    end
    return w;
  endfunction

  // Clean press on both instances; captures leds just before and just after
  // the expected update edge, plus wrap on and after that edge.
  task automatic do_press(input logic [1:0] ma, mb, da, db, ca);
    epre_a = exp_leds(0); epre_b = exp_leds(1);
    @(negedge clk); btn_a = ma; btn_b = mb; dir_a = da; dir_b = db;
    repeat (DELAY + 2) @(posedge clk);
    @(negedge clk); pre_a = leds_a; pre_b = leds_b; clr_a = ca;
    @(posedge clk); #1;
    post_a = leds_a; post_b = leds_b; w_a = wrap_a; w_b = wrap_b; clr_a = '0;
    @(posedge clk); #1;
    wn_a = wrap_a; wn_b = wrap_b;
    btn_a = '0; btn_b = '0;
    repeat (DELAY + 4) @(posedge clk);
    ew_a = mstep(0, ma, da, ca);
    ew_b = mstep(1, mb, db, 2'b00);
  endtask

  task automatic do_clear(input logic [1:0] ca, cb);
    @(negedge clk); clr_a = ca; clr_b = cb;
    @(posedge clk); #1; clr_a = '0; clr_b = '0;
    ew_a = mstep(0, 2'b00, 2'b00, ca);
    ew_b = mstep(1, 2'b00, 2'b00, cb);
  endtask

  task automatic test_reset();
    btn_a = 2'b11; btn_b = 2'b11; rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({leds_a, leds_b, wrap_a, wrap_b} !== 20'h0) begin
        errors++; $display("FAIL reset_hold cyc %0d got %h exp 0", i, {leds_a, leds_b, wrap_a, wrap_b});
      end
    end
    btn_a = '0; btn_b = '0;
    @(negedge clk); rst = 1'b1;
    repeat (DELAY + 4) @(posedge clk);
    foreach (mdl[i, j]) mdl[i][j] = 0;
  endtask

  task automatic test_bounce();
    @(negedge clk); btn_a = 2'b01; dir_a = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 btn_a = 2'b00;
    #5 btn_a = 2'b01;            // last rise, 2 time units after an edge
    @(posedge clk);              // first sampling edge t
    repeat (DELAY + 1) @(posedge clk); #1;
    checks++;
    if (leds_a !== 8'h00) begin errors++; $display("FAIL bounce_early got %h exp 00", leds_a); end
    @(posedge clk); #1;
    checks++;
    if (leds_a !== 8'h01) begin errors++; $display("FAIL bounce_step got %h exp 01", leds_a); end
    repeat (3 * DELAY) @(posedge clk); #1;
    checks++;
    if (leds_a !== 8'h01) begin errors++; $display("FAIL bounce_single got %h exp 01", leds_a); end
    btn_a = '0;
    repeat (DELAY + 4) @(posedge clk);
    mdl[0][0] = 1;
  endtask

  task automatic test_full_cycle();
    logic [3:0] seq [16];
    seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    do_clear(2'b01, 2'b00);
    checks++;
    if (leds_a[3:0] !== 4'h0) begin errors++; $display("FAIL clear0 got %h exp 0", leds_a[3:0]); end
    for (int i = 0; i < 16; i++) begin
      do_press(2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
      checks++;
      if (pre_a !== epre_a) begin errors++; $display("FAIL cycle_latency %0d got %h exp %h", i, pre_a, epre_a); end
      checks++;
      if (post_a[3:0] !== seq[i]) begin errors++; $display("FAIL cycle_val %0d got %h exp %h", i, post_a[3:0], seq[i]); end
      checks++;
      if (w_a !== ((i == 15) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL cycle_wrap %0d got %b exp %b", i, w_a, (i == 15) ? 2'b01 : 2'b00); end
    end
  endtask

  task automatic test_down_sat();
    do_clear(2'b11, 2'b11);
    do_press(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    checks++;
    if (post_a[3:0] !== 4'h8 || w_a !== 2'b01 || wn_a !== 2'b00) begin
      errors++; $display("FAIL down_wrap got %h/%b/%b exp 8/01/00", post_a[3:0], w_a, wn_a);
    end
    checks++;
    if (post_b[3:0] !== 4'h0 || w_b !== 2'b01 || wn_b !== 2'b00) begin
      errors++; $display("FAIL down_sat got %h/%b/%b exp 0/01/00", post_b[3:0], w_b, wn_b);
    end
    for (int i = 0; i < 15; i++) begin
      do_press(2'b00, 2'b10, 2'b00, 2'b10, 2'b00);
      checks++;
      if (post_b !== exp_leds(1) || w_b !== 2'b00) begin
        errors++; $display("FAIL sat_climb %0d got %h/%b exp %h/00", i, post_b, w_b, exp_leds(1));
      end
    end
    do_press(2'b00, 2'b10, 2'b00, 2'b10, 2'b00);
    checks++;
    if (post_b[7:4] !== 4'h8 || w_b !== 2'b10) begin
      errors++; $display("FAIL up_sat got %h/%b exp 8/10", post_b[7:4], w_b);
    end
    checks++;
    if (post_a !== 8'h08) begin errors++; $display("FAIL sat_isolation got %h exp 08", post_a); end
  endtask

  task automatic test_concurrency_clear();
    do_clear(2'b11, 2'b00);
    do_press(2'b11, 2'b00, 2'b01, 2'b00, 2'b00);
    checks++;
    if (post_a !== 8'h81 || w_a !== 2'b10) begin
      errors++; $display("FAIL concurrent got %h/%b exp 81/10", post_a, w_a);
    end
    do_press(2'b01, 2'b00, 2'b01, 2'b00, 2'b01);
    checks++;
    if (post_a !== 8'h80 || w_a !== 2'b00) begin
      errors++; $display("FAIL clr_priority got %h/%b exp 80/00", post_a, w_a);
    end
  endtask

  task automatic test_random();
    logic [1:0] ma, mb, da, db, ca;
    for (int i = 0; i < 24; i++) begin
      ma = 2'($urandom_range(0, 3)); mb = 2'($urandom_range(0, 3));
      da = 2'($urandom_range(0, 3)); db = 2'($urandom_range(0, 3));
      ca = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_press(ma, mb, da, db, ca);
      checks++;
      if (pre_a !== epre_a || pre_b !== epre_b) begin
        errors++; $display("FAIL rnd_pre %0d got %h %h exp %h %h", i, pre_a, pre_b, epre_a, epre_b);
      end
      checks++;
      if (post_a !== exp_leds(0) || post_b !== exp_leds(1)) begin
        errors++; $display("FAIL rnd_leds %0d got %h %h exp %h %h", i, post_a, post_b, exp_leds(0), exp_leds(1));
      end
      checks++;
      if (w_a !== ew_a || w_b !== ew_b || wn_a !== 2'b00 || wn_b !== 2'b00) begin
        errors++; $display("FAIL rnd_wrap %0d got %b %b %b %b exp %b %b 00 00", i, w_a, w_b, wn_a, wn_b, ew_a, ew_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_clear(2'b11, 2'b11);
    do_press(2'b10, 2'b01, 2'b10, 2'b01, 2'b00);
    @(negedge clk); btn_a = 2'b01; dir_a = 2'b01;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({leds_a, leds_b, wrap_a, wrap_b} !== 20'h0) begin
      errors++; $display("FAIL async_reset got %h exp 0", {leds_a, leds_b, wrap_a, wrap_b});
    end
    foreach (mdl[i, j]) mdl[i][j] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (DELAY + 2) @(posedge clk); #1;
    checks++;
    if (leds_a !== 8'h00) begin errors++; $display("FAIL reset_repress_early got %h exp 00", leds_a); end
    @(posedge clk); #1;
    checks++;
    if (leds_a !== 8'h01) begin errors++; $display("FAIL reset_repress got %h exp 01", leds_a); end
    btn_a = '0;
    repeat (DELAY + 4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_full_cycle();
    test_down_sat();
    test_concurrency_clear();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
